audio_mixer_n: RTL and testbench

Parametrised, time-multiplexed N-channel audio mixer for the `clk_sys` domain. It sits between the machine core's sound sources (PSG/beeper, cassette in/out bits, future sound boards) and the sigma-delta DAC, I2S and S/PDIF outputs. On each sample strobe it snapshots all channels, applies per-channel enable and power-of-two gain, and accumulates the channels serially. It then applies master attenuation, saturates to the output width, and presents the result in both signed and offset-binary form.

---
 rtl/audio_mixer_n_pkg.sv | 18 +
 rtl/audio_mixer_n_if.sv | 31 +++
 rtl/audio_mixer_n_sat.sv | 33 +++
 rtl/audio_mixer_n.sv | 128 ++++++++++++
 tb/tb_audio_mixer_n.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/audio_mixer_n_pkg.sv
// Shared types and sizing helpers for the time-multiplexed audio mixer.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2,
        ST_DONE = 2'd3
    } mix_state_e;

    localparam int ATT_W = 2;

    // Room for the largest shifted term plus growth from summing every channel.
    function automatic int acc_w(input int in_w, input int shift_w, input int channels);
        return in_w + (1 << shift_w) - 1 + $clog2(channels) + 1;
    endfunction

endpackage

// File: rtl/audio_mixer_n_if.sv
// Sample-strobe, channel-input and mixed-output bundle between the sound core and the mixer.
interface audio_mixer_n_if
    import audio_mix_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 9,
    parameter int OUT_W    = 15,
    parameter int SHIFT_W  = 3
);
    logic                          ce_sample;
    logic [CHANNELS*IN_W-1:0]      ch_data;
    logic [CHANNELS-1:0]           ch_en;
    logic [CHANNELS*SHIFT_W-1:0]   ch_shift;
    logic [ATT_W-1:0]              master_att;
    logic                          busy;
    logic                          out_valid;
    logic [OUT_W-1:0]              out_signed;
    logic [OUT_W-1:0]              out_unsigned;
    logic                          clip;
    logic                          overrun;

    modport master (
        output ce_sample, ch_data, ch_en, ch_shift, master_att,
        input  busy, out_valid, out_signed, out_unsigned, clip, overrun
    );

    modport slave (
        input  ce_sample, ch_data, ch_en, ch_shift, master_att,
        output busy, out_valid, out_signed, out_unsigned, clip, overrun
    );
endinterface

// File: rtl/audio_mixer_n_sat.sv
// Master attenuation (arithmetic right shift) followed by saturation to the output width.
module audio_sat
    import audio_mix_pkg::*;
#(
    parameter int ACC_W = 19,
    parameter int OUT_W = 15
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [ATT_W-1:0] att_i,
    output logic signed [OUT_W-1:0] sat_o,
    output logic                    clip_o
);
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] t;
    logic signed [EXT_W-1:0] t_ext;

    always_comb begin
        t      = acc_i >>> att_i;
        t_ext  = EXT_W'(t);
        sat_o  = t_ext[OUT_W-1:0];
        clip_o = 1'b0;
        if (t_ext > MAX_V) begin
            sat_o  = MAX_V[OUT_W-1:0];
            clip_o = 1'b1;
        end else if (t_ext < MIN_V) begin
            sat_o  = MIN_V[OUT_W-1:0];
            clip_o = 1'b1;
        end
    end
endmodule

// File: rtl/audio_mixer_n.sv
// N-channel serial mixer: snapshot on strobe, accumulate one channel per cycle,
// attenuate and saturate, then present signed and offset-binary results.
//   state | meaning
//   IDLE  | waiting for ce_sample
//   ACC   | adding the term of channel idx_q
//   SAT   | registering attenuated, saturated sum
//   DONE  | new outputs valid; may accept the next strobe
module audio_mixer_n
    import audio_mix_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 9,
    parameter int OUT_W    = 15,
    parameter int SHIFT_W  = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    audio_mixer_n_if.slave mix
);
    localparam int ACC_W = acc_w(IN_W, SHIFT_W, CHANNELS);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    mix_state_e              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [IN_W-1:0]         data_q  [CHANNELS];
    logic [SHIFT_W-1:0]      shift_q [CHANNELS];
    logic [CHANNELS-1:0]     en_q;
    logic [ATT_W-1:0]        att_q;
    logic signed [OUT_W-1:0] out_q;
    logic                    clip_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic [IN_W-1:0]         cur_data;
    logic signed [IN_W-1:0]  centered;
    logic signed [ACC_W-1:0] term;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_clip;
    logic                    accept;

    // Offset-binary to two's complement is just an MSB flip.
    always_comb begin
        cur_data = data_q[idx_q];
        centered = signed'({~cur_data[IN_W-1], cur_data[IN_W-2:0]});
        term     = '0;
        if (en_q[idx_q]) begin
            term = ACC_W'(centered) <<< shift_q[idx_q];
        end
    end

    assign accept = mix.ce_sample && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    audio_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc_i  (acc_q),
        .att_i  (att_q),
        .sat_o  (sat_val),
        .clip_o (sat_clip)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            en_q      <= '0;
            att_q     <= '0;
            out_q     <= '0;
            clip_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                data_q[i]  <= '0;
                shift_q[i] <= '0;
            end
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= mix.ce_sample && ((state_q == ST_ACC) || (state_q == ST_SAT));
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            data_q[i]  <= mix.ch_data[i*IN_W +: IN_W];
                            shift_q[i] <= mix.ch_shift[i*SHIFT_W +: SHIFT_W];
                        end
                        en_q    <= mix.ch_en;
                        att_q   <= mix.master_att;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    acc_q <= acc_q + term;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_SAT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_SAT: begin
                    out_q   <= sat_val;
                    clip_q  <= sat_clip;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mix.busy         = busy_q;
    assign mix.out_valid    = valid_q;
    assign mix.out_signed   = out_q;
    assign mix.out_unsigned = {~out_q[OUT_W-1], out_q[OUT_W-2:0]};
    assign mix.clip         = clip_q;
    assign mix.overrun      = overrun_q;
endmodule

// File: tb/tb_audio_mixer_n.sv
// Directed bench for audio_mixer_n with two channels and hand-computed results.
module tb_audio_mixer_n;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    audio_mixer_n_if #(.CHANNELS(2), .IN_W(9), .OUT_W(15), .SHIFT_W(3)) mif ();

    audio_mixer_n #(.CHANNELS(2), .IN_W(9), .OUT_W(15), .SHIFT_W(3)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .mix     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [8:0] d1, input logic [8:0] d0, input logic [1:0] en,
                         input logic [2:0] s1, input logic [2:0] s0, input logic [1:0] att);
        mif.ch_data    = {d1, d0};
        mif.ch_en      = en;
        mif.ch_shift   = {s1, s0};
        mif.master_att = att;
    endtask

    // mode 0: plain pass, 1: change ch_data in cycle 2, 2: extra strobe in cycle 2
    task automatic do_pass(input string tag, input logic [14:0] exp_s, input logic exp_clip,
                           input int mode, input logic [17:0] mid);
        int n;
        mif.ce_sample = 1'b1;
        @(negedge clk);
        mif.ce_sample = 1'b0;
        n = 1;
        check({tag, " busy"}, 32'(mif.busy), 32'd1);
        while (n < 12 && !mif.out_valid) begin
            if (n == 2 && mode == 1) mif.ch_data = mid;
            if (n == 2 && mode == 2) mif.ce_sample = 1'b1;
            @(negedge clk);
            n++;
            if (n == 3 && mode == 2) begin
                mif.ce_sample = 1'b0;
                check({tag, " overrun"}, 32'(mif.overrun), 32'd1);
            end
        end
        check({tag, " cycle"}, 32'(n), 32'd4);
        check({tag, " valid"}, 32'(mif.out_valid), 32'd1);
        check({tag, " signed"}, 32'(mif.out_signed), 32'(exp_s));
        check({tag, " unsigned"}, 32'(mif.out_unsigned), 32'(exp_s ^ 15'h4000));
        check({tag, " clip"}, 32'(mif.clip), 32'(exp_clip));
        check({tag, " busy done"}, 32'(mif.busy), 32'd0);
        check({tag, " overrun done"}, 32'(mif.overrun), 32'd0);
    endtask

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        mif.ce_sample = 1'b0;
        setup(9'h100, 9'h100, 2'b11, 3'd0, 3'd0, 2'd0);
        repeat (2) @(negedge clk);
        check("rst signed", 32'(mif.out_signed), 32'h0);
        check("rst unsigned", 32'(mif.out_unsigned), 32'h4000);
        check("rst flags", {28'd0, mif.busy, mif.out_valid, mif.clip, mif.overrun}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        setup(9'h100, 9'h1FF, 2'b11, 3'd0, 3'd0, 2'd0);
        do_pass("basic", 15'd255, 1'b0, 0, 18'd0);
        @(negedge clk);
        check("hold signed", 32'(mif.out_signed), 32'd255);
        check("hold valid", 32'(mif.out_valid), 32'd0);

        setup(9'h080, 9'h180, 2'b11, 3'd5, 3'd5, 2'd0);
        do_pass("cancel", 15'd0, 1'b0, 0, 18'd0);
        @(negedge clk);

        setup(9'h1FF, 9'h1FF, 2'b11, 3'd7, 3'd7, 2'd0);
        do_pass("pos sat", 15'h3FFF, 1'b1, 0, 18'd0);
        @(negedge clk);

        setup(9'h000, 9'h000, 2'b11, 3'd7, 3'd7, 2'd0);
        do_pass("neg sat", 15'h4000, 1'b1, 0, 18'd0);
        @(negedge clk);

        // 255<<6 + 63 = 16383 exactly at the positive limit
        setup(9'h13F, 9'h1FF, 2'b11, 3'd0, 3'd6, 2'd0);
        do_pass("max edge", 15'h3FFF, 1'b0, 0, 18'd0);
        @(negedge clk);
        setup(9'h140, 9'h1FF, 2'b11, 3'd0, 3'd6, 2'd0);
        do_pass("max over", 15'h3FFF, 1'b1, 0, 18'd0);
        @(negedge clk);
        setup(9'h100, 9'h000, 2'b11, 3'd0, 3'd6, 2'd0);
        do_pass("min edge", 15'h4000, 1'b0, 0, 18'd0);
        @(negedge clk);
        setup(9'h0FF, 9'h000, 2'b11, 3'd0, 3'd6, 2'd0);
        do_pass("min over", 15'h4000, 1'b1, 0, 18'd0);
        @(negedge clk);

        // 1<<3 + (-1)<<1 = 6
        setup(9'h0FF, 9'h101, 2'b11, 3'd1, 3'd3, 2'd0);
        do_pass("per-ch shift", 15'd6, 1'b0, 0, 18'd0);
        @(negedge clk);

        setup(9'h1FF, 9'h1FF, 2'b01, 3'd7, 3'd0, 2'd2);
        do_pass("en att", 15'd63, 1'b0, 1, 18'd0);
        @(negedge clk);

        // -256 >>> 3 = -32
        setup(9'h1FF, 9'h000, 2'b01, 3'd7, 3'd0, 2'd3);
        do_pass("neg att", 15'h7FE0, 1'b0, 0, 18'd0);
        @(negedge clk);

        setup(9'h100, 9'h1FF, 2'b11, 3'd0, 3'd0, 2'd0);
        do_pass("overrun", 15'd255, 1'b0, 2, 18'd0);
        setup(9'h101, 9'h180, 2'b11, 3'd0, 3'd0, 2'd0);
        do_pass("back2back", 15'd129, 1'b0, 0, 18'd0);
        @(negedge clk);

        mif.ce_sample = 1'b1;
        @(negedge clk);
        mif.ce_sample = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort signed", 32'(mif.out_signed), 32'h0);
        check("abort unsigned", 32'(mif.out_unsigned), 32'h4000);
        check("abort flags", {28'd0, mif.busy, mif.out_valid, mif.clip, mif.overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (mif.out_valid) seen++;
        end
        check("abort no valid", 32'(seen), 32'd0);
        check("abort busy", 32'(mif.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
